// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED fade driver:
//   - chan_state_t : per-channel ramp state encoding
//                    (IDLE=0, ATTACK=1, HOLD=2, DECAY=3)
//   - DEF_PWM_BITS / DEF_NUM_LEDS : default geometry for the iCEstick build
//   - clamp_add / clamp_sub : saturating level arithmetic
// The helpers work on a fixed CALC_W-bit operand. That covers levels up to
// 16 bits plus one carry bit, so a sum never wraps before it is clamped.
// -----------------------------------------------------------------------------
package led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ATTACK = 2'd1,
        ST_HOLD   = 2'd2,
        ST_DECAY  = 2'd3
    } chan_state_t;

    localparam int DEF_PWM_BITS = 8;
    localparam int DEF_NUM_LEDS = 4;

    // Widest supported level (16 bits) plus a carry bit.
    localparam int CALC_W = 17;

    // min(a + b, max_v); the sum cannot overflow CALC_W for 16-bit operands.
    function automatic logic [CALC_W-1:0] clamp_add(
        input logic [CALC_W-1:0] a,
        input logic [CALC_W-1:0] b,
        input logic [CALC_W-1:0] max_v
    );
        logic [CALC_W-1:0] sum;
        sum = a + b;
        return (sum > max_v) ? max_v : sum;
    endfunction

    // max(a - b, 0) without ever wrapping below zero.
    function automatic logic [CALC_W-1:0] clamp_sub(
        input logic [CALC_W-1:0] a,
        input logic [CALC_W-1:0] b
    );
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// -----------------------------------------------------------------------------
// led_pwm_channel
// One LED channel: brightness level register, attack/decay ramp FSM, duty
// latch and PWM comparator.
//
// Configuration macro: LED_FADE_GAMMA_EN
//   defined     : the duty latch takes (level*level) >> PWM_BITS, and MAX maps to MAX
//   not defined : the duty latch takes the level directly (linear fade)
//
// Ports
//   clk        in   1         system clock
//   rst        in   1         synchronous reset, active-high
//   step_tick  in   1         one-clk ramp step strobe from the shared prescaler
//   req        in   1         1 = ramp towards full, 0 = decay towards off
//   pwm_cnt    in   PWM_BITS  shared free-running PWM counter
//   led        out  1         registered PWM drive for this LED
//   level      out  PWM_BITS  current brightness level
// -----------------------------------------------------------------------------
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS    = DEF_PWM_BITS,
    parameter int ATTACK_STEP = 255,
    parameter int DECAY_STEP  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step_tick,
    input  logic                req,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led,
    output logic [PWM_BITS-1:0] level
);

    localparam logic [PWM_BITS-1:0] MAX   = '1;
    localparam logic [CALC_W-1:0]   MAX_W = CALC_W'(MAX);
    localparam logic [CALC_W-1:0]   ATT_W = CALC_W'(ATTACK_STEP);
    localparam logic [CALC_W-1:0]   DEC_W = CALC_W'(DECAY_STEP);

    chan_state_t         state;
    logic [CALC_W-1:0]   level_w;
    logic [CALC_W-1:0]   next_w;
    logic [PWM_BITS-1:0] next_level;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] duty_src;
    logic                at_max;
    logic                at_zero;
    logic                wrap;

    // The candidate level is computed in the wider domain and then clamped.
    // After clamping it always fits back into PWM_BITS.
    always_comb begin
        level_w    = CALC_W'(level);
        next_w     = req ? clamp_add(level_w, ATT_W, MAX_W) : clamp_sub(level_w, DEC_W);
        next_level = next_w[PWM_BITS-1:0];
        at_max     = (next_level == MAX);
        at_zero    = (next_level == '0);
    end

    assign wrap = (pwm_cnt == MAX);

    // The level and the ramp state move only on step_tick. The state is chosen
    // from the request and the post-update level, so IDLE and HOLD always match
    // level 0 and level MAX.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
            state <= ST_IDLE;
        end else if (step_tick) begin
            level <= next_level;
            case (state)
                ST_IDLE: begin
                    if (req) state <= at_max ? ST_HOLD : ST_ATTACK;
                end
                ST_ATTACK: begin
                    if (!req)        state <= at_zero ? ST_IDLE : ST_DECAY;
                    else if (at_max) state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!req) state <= at_zero ? ST_IDLE : ST_DECAY;
                end
                ST_DECAY: begin
                    if (req)          state <= at_max ? ST_HOLD : ST_ATTACK;
                    else if (at_zero) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef LED_FADE_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_sq;

    // Squaring gives a perceptually even fade. Full scale is pinned to MAX so
    // that the LED still reaches true full-on.
    always_comb begin
        level_sq = {{PWM_BITS{1'b0}}, level} * {{PWM_BITS{1'b0}}, level};
        duty_src = (level == MAX) ? MAX : level_sq[2*PWM_BITS-1:PWM_BITS];
    end
`else
    assign duty_src = level;
`endif

    // Duty is latched only at the period boundary, so each PWM period is clean.
    // The latch reads the pre-update level. A step on the wrap cycle therefore
    // becomes visible one period later.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty <= '0;
            led  <= 1'b0;
        end else begin
            if (wrap) duty <= duty_src;
            led <= (pwm_cnt < duty) || (duty == MAX);
        end
    end

endmodule

// File: rtl/led_fade_driver.sv
// -----------------------------------------------------------------------------
// led_fade_driver
// PWM LED driver that gives every channel a soft attack/decay ramp, so a
// rotating one-hot request pattern shows up as a fading comet trail.
// This block owns the shared step prescaler, the free-running PWM counter,
// the frame strobe and the busy reduction. Each LED gets one led_pwm_channel.
//
// Configuration macro: LED_FADE_GAMMA_EN (gamma-corrected duty, see
// led_pwm_channel). When it is undefined the fade is linear.
//
// Ports
//   clk        in   1         system clock (12 MHz on the iCEstick)
//   rst        in   1         synchronous reset, active-high
//   en_i       in   1         ramp enable; low freezes the prescaler and all levels
//   led_req_i  in   NUM_LEDS  per-channel request (1 = ramp up, 0 = decay)
//   led_o      out  NUM_LEDS  registered PWM drive to the LED pins, active-high
//   frame_o    out  1         one-clk pulse on the cycle pwm_cnt has wrapped to 0
//   busy_o     out  1         registered: high while any channel level is non-zero
// -----------------------------------------------------------------------------
module led_fade_driver
    import led_pkg::*;
#(
    parameter int NUM_LEDS    = DEF_NUM_LEDS,
    parameter int PWM_BITS    = DEF_PWM_BITS,
    parameter int STEP_CYCLES = 46875,
    parameter int ATTACK_STEP = 255,
    parameter int DECAY_STEP  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_i,
    input  logic [NUM_LEDS-1:0] led_req_i,
    output logic [NUM_LEDS-1:0] led_o,
    output logic                frame_o,
    output logic                busy_o
);

    localparam int                  PRE_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] MAX      = '1;

    logic [PRE_W-1:0]    prescaler;
    logic                step_tick;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] level [NUM_LEDS];
    logic [NUM_LEDS-1:0] level_nz;

    // The prescaler holds its count while en_i is low, so a pause does not
    // restart the current step interval.
    assign step_tick = en_i && (prescaler == PRE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
        end else if (en_i) begin
            prescaler <= step_tick ? '0 : prescaler + 1'b1;
        end
    end

    // The PWM runs regardless of en_i. A frozen level keeps glowing at its
    // frozen duty.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
            frame_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            // Marks the cycle where pwm_cnt holds 0 after a wrap. The cycle
            // after reset is not a wrap, so it does not pulse.
            frame_o <= (pwm_cnt == MAX);
            busy_o  <= |level_nz;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : gen_ch
        led_pwm_channel #(
            .PWM_BITS    (PWM_BITS),
            .ATTACK_STEP (ATTACK_STEP),
            .DECAY_STEP  (DECAY_STEP)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .step_tick (step_tick),
            .req       (led_req_i[i]),
            .pwm_cnt   (pwm_cnt),
            .led       (led_o[i]),
            .level     (level[i])
        );

        assign level_nz[i] = (level[i] != '0);
    end

endmodule

// File: tb/tb_led_fade_driver.sv
module tb_led_fade_driver;
  localparam int NL   = 4;
  localparam int PB   = 4;
  localparam int SC   = 4;
  localparam int AS   = 15;
  localparam int DS   = 4;
  localparam int MAXV = 15;

`ifdef LED_FADE_GAMMA_EN
  localparam int EXP_L7 = 3;
`else
  localparam int EXP_L7 = 7;
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en_i = 1'b1;
  logic [NL-1:0] led_req_i = '0;
  logic [NL-1:0] led_o;
  logic          frame_o;
  logic          busy_o;

  always #5 clk = ~clk;

  led_fade_driver #(
    .NUM_LEDS(NL), .PWM_BITS(PB), .STEP_CYCLES(SC),
    .ATTACK_STEP(AS), .DECAY_STEP(DS)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .led_req_i(led_req_i),
    .led_o(led_o), .frame_o(frame_o), .busy_o(busy_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endfunction

  // ---------------- reference model + scoreboard ----------------
  logic [5:0] exp_q[$];
  int         m_presc, m_pwm;
  int         m_level [NL];
  int         m_duty  [NL];
  logic [NL-1:0] m_led;
  logic       m_frame, m_busy;

  function automatic int gamma_of(int lv);
`ifdef LED_FADE_GAMMA_EN
    if (lv == MAXV) return MAXV;
    return (lv * lv) >> PB;
`else
    return lv;
`endif
  endfunction

  always @(posedge clk) begin : model
    bit tick;
    if (rst) begin
      m_presc = 0; m_pwm = 0; m_led = '0; m_frame = 1'b0; m_busy = 1'b0;
      for (int i = 0; i < NL; i++) begin m_level[i] = 0; m_duty[i] = 0; end
    end else begin
      tick   = en_i && (m_presc == SC - 1);
      m_busy = 1'b0;
      for (int i = 0; i < NL; i++) begin
        if (m_level[i] != 0) m_busy = 1'b1;
        m_led[i] = (m_pwm < m_duty[i]) || (m_duty[i] == MAXV);
        if (m_pwm == MAXV) m_duty[i] = gamma_of(m_level[i]);
        if (tick) begin
          if (led_req_i[i]) m_level[i] = (m_level[i] + AS > MAXV) ? MAXV : m_level[i] + AS;
          else              m_level[i] = (m_level[i] < DS) ? 0 : m_level[i] - DS;
        end
      end
      m_frame = (m_pwm == MAXV);
      m_pwm   = (m_pwm + 1) % (MAXV + 1);
      if (en_i) m_presc = tick ? 0 : m_presc + 1;
    end
    exp_q.push_back({m_led, m_frame, m_busy});
  end

  always @(negedge clk) begin : scoreboard
    logic [5:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scoreboard_led_frame_busy", 32'({led_o, frame_o, busy_o}), 32'(e));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_frame(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (frame_o === 1'b1) begin seen = 1'b1; break; end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic count_high(input int ch, output int cnt);
    cnt = 0;
    repeat (16) begin
      @(negedge clk);
      if (led_o[ch] === 1'b1) cnt++;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [3:0]      req;
    logic            en;
    logic [7:0]      settle;
    logic [3:0][4:0] exp_cnt;   // {ch3, ch2, ch1, ch0} high clocks per period
    logic            exp_busy;
  } vec_t;

  vec_t vecs [6];

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int cnt;
    int gap;
    vecs[0] = '{req:4'b1111, en:1'b1, settle:8'd40, exp_cnt:{5'd16, 5'd16, 5'd16, 5'd16}, exp_busy:1'b1};
    vecs[1] = '{req:4'b0101, en:1'b1, settle:8'd40, exp_cnt:{5'd0,  5'd16, 5'd0,  5'd16}, exp_busy:1'b1};
    vecs[2] = '{req:4'b0000, en:1'b1, settle:8'd48, exp_cnt:{5'd0,  5'd0,  5'd0,  5'd0 }, exp_busy:1'b0};
    vecs[3] = '{req:4'b1000, en:1'b0, settle:8'd40, exp_cnt:{5'd0,  5'd0,  5'd0,  5'd0 }, exp_busy:1'b0};
    vecs[4] = '{req:4'b1000, en:1'b1, settle:8'd40, exp_cnt:{5'd16, 5'd0,  5'd0,  5'd0 }, exp_busy:1'b1};
    vecs[5] = '{req:4'b0110, en:1'b1, settle:8'd40, exp_cnt:{5'd0,  5'd16, 5'd16, 5'd0 }, exp_busy:1'b1};

    // Reset held for 3 clocks while requests are asserted.
    rst = 1'b1; en_i = 1'b1; led_req_i = 4'b1111;
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", 32'({led_o, frame_o, busy_o}), 32'd0);
    end
    rst = 1'b0; led_req_i = 4'b0000;
    @(negedge clk);
    check("after_release_outputs", 32'({led_o, frame_o, busy_o}), 32'd0);

    // A step that lands on the wrap edge: that period keeps the old duty (0).
    wait_frame("frame_seen_1");
    repeat (12) @(negedge clk);
    led_req_i = 4'b0001;
    repeat (4) @(negedge clk);
    check("coinc_frame", 32'(frame_o), 32'd1);
    check("coinc_busy_lag", 32'(busy_o), 32'd0);
    count_high(0, cnt);
    check("coinc_old_duty", 32'(cnt), 32'd0);
    count_high(0, cnt);
    check("full_on_period", 32'(cnt), 32'd16);
    check("busy_after_attack", 32'(busy_o), 32'd1);
    check("other_leds_off", 32'(led_o[3:1]), 32'd0);

    // Decay 15 -> 11 -> 7, then freeze the ramp at level 7 for 40 clocks.
    led_req_i = 4'b0000;
    repeat (8) @(negedge clk);
    check("busy_mid_decay", 32'(busy_o), 32'd1);
    en_i = 1'b0;
    repeat (8) @(negedge clk);
    check("frozen_frame", 32'(frame_o), 32'd1);
    count_high(0, cnt);
    check("duty_level7", 32'(cnt), 32'(EXP_L7));
    count_high(0, cnt);
    check("duty_level7_frozen", 32'(cnt), 32'(EXP_L7));
    check("busy_frozen", 32'(busy_o), 32'd1);

    // Resume from the held prescaler: 7 -> 3 -> 0; busy lags level by one clock.
    en_i = 1'b1;
    repeat (8) @(negedge clk);
    check("busy_one_clk_after_zero", 32'(busy_o), 32'd1);
    @(negedge clk);
    check("busy_fall", 32'(busy_o), 32'd0);

    // Steady-state vector table.
    for (int v = 0; v < 6; v++) begin
      int c4 [NL];
      led_req_i = vecs[v].req;
      en_i      = vecs[v].en;
      repeat (int'(vecs[v].settle)) @(negedge clk);
      for (int c = 0; c < NL; c++) c4[c] = 0;
      repeat (16) begin
        @(negedge clk);
        for (int c = 0; c < NL; c++) if (led_o[c] === 1'b1) c4[c]++;
      end
      for (int c = 0; c < NL; c++)
        check($sformatf("vec%0d_ch%0d_duty", v, c), 32'(c4[c]), 32'(vecs[v].exp_cnt[c]));
      check($sformatf("vec%0d_busy", v), 32'(busy_o), 32'(vecs[v].exp_busy));
    end

    // Reset in the middle of a ramp clears everything on the next clock.
    led_req_i = 4'b1111; en_i = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midramp_reset_outputs", 32'({led_o, frame_o, busy_o}), 32'd0);
    rst = 1'b0; led_req_i = 4'b0000;
    @(negedge clk);
    check("midramp_release_outputs", 32'({led_o, frame_o, busy_o}), 32'd0);
    repeat (20) @(negedge clk);
    check("no_state_survives_reset", 32'({led_o, busy_o}), 32'd0);

    // Frame period.
    wait_frame("frame_seen_2");
    gap = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (frame_o === 1'b1) begin gap = k; break; end
    end
    check("frame_period", 32'(gap), 32'd16);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
